// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deframe bytes,
// fold E0/F0 prefixes into flags and queue decoded keys in a show-ahead FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 20,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          kclk,
  input  logic                          kdata,
  output logic [7:0]                    code_data,
  output logic                          code_ext,
  output logic                          code_break,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  FL_MAX = 8'(FILTER_LEN - 1);
  localparam logic [19:0] TO_MAX = 20'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] ONE    = (AW+1)'(1);
  localparam logic [AW:0] FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_e;

  logic [1:0] pin;
  logic [1:0] s1_q, s2_q, flt_q;
  logic [7:0] fcnt_q [2];
  logic       kclk_prev_q;

  assign pin = {kdata, kclk};

  // Index 0 is kclk, index 1 is kdata; both idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 2'b11;
      s2_q        <= 2'b11;
      flt_q       <= 2'b11;
      kclk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= 8'd0;
    end else begin
      s1_q        <= pin;
      s2_q        <= s1_q;
      kclk_prev_q <= flt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == flt_q[i]) begin
          fcnt_q[i] <= 8'd0;
        end else if (fcnt_q[i] == FL_MAX) begin
          flt_q[i]  <= s2_q[i];
          fcnt_q[i] <= 8'd0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  logic fall, kd;
  assign fall = kclk_prev_q & ~flt_q[0];
  assign kd   = flt_q[1];

  st_e         state_q;
  logic [2:0]  bcnt_q;
  logic [7:0]  sr_q;
  logic        par_q;
  logic [19:0] to_q;
  logic        perr_q, ferr_q, ext_q, brk_q, ovf_q;

  logic timeout, stop_edge, par_ok, is_e0, is_f0, push;
  assign timeout   = (state_q != IDLE) & ~fall & (to_q == TO_MAX);
  assign stop_edge = (state_q == STOP) & fall;
  assign par_ok    = ^{sr_q, par_q};
  assign is_e0     = (sr_q == 8'hE0);
  assign is_f0     = (sr_q == 8'hF0);
  assign push      = stop_edge & kd & par_ok & ~is_e0 & ~is_f0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= 3'd0;
      sr_q    <= 8'd0;
      par_q   <= 1'b0;
      to_q    <= 20'd0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (fall || timeout) to_q <= 20'd0;
      else if (state_q != IDLE) to_q <= to_q + 20'd1;
      if (timeout) begin
        state_q <= IDLE;
        ferr_q  <= 1'b1;
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
      end else if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (!kd) begin
              state_q <= DATA;
              bcnt_q  <= 3'd0;
            end else begin
              ferr_q <= 1'b1;
              ext_q  <= 1'b0;
              brk_q  <= 1'b0;
            end
          end
          DATA: begin
            sr_q   <= {kd, sr_q[7:1]};
            bcnt_q <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= kd;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            priority case (1'b1)
              !kd:     begin ferr_q <= 1'b1; ext_q <= 1'b0; brk_q <= 1'b0; end
              !par_ok: begin perr_q <= 1'b1; ext_q <= 1'b0; brk_q <= 1'b0; end
              is_e0:   ext_q <= 1'b1;
              is_f0:   brk_q <= 1'b1;
              default: begin ext_q <= 1'b0; brk_q <= 1'b0; end
            endcase
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q, level_d;
  logic          pop, full, wr_en;

  assign code_valid = (level_q != '0);
  assign pop        = code_valid & code_ready;
  assign full       = (level_q == FULL);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en      = push & (~full | pop);

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop) level_d = level_q + ONE;
    else if (!wr_en && pop) level_d = level_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= {ext_q, brk_q, sr_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign {code_ext, code_break, code_data} = code_valid ? mem[rd_q] : 10'd0;
  assign fifo_level = level_q;
  assign err_parity = perr_q;
  assign err_frame  = ferr_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frame-level model feeds an expected queue,
// a monitor pops it on every handshake.
module tb_ps2_rx_fifo;
  localparam int FL = 4;
  localparam int DEPTH = 8;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n, kclk, kdata, code_ready;
  logic [7:0] code_data;
  logic       code_ext, code_break, code_valid;
  logic [3:0] fifo_level;
  logic       err_parity, err_frame, overflow;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
    .code_data(code_data), .code_ext(code_ext), .code_break(code_break),
    .code_valid(code_valid), .code_ready(code_ready),
    .fifo_level(fifo_level), .err_parity(err_parity),
    .err_frame(err_frame), .overflow(overflow)
  );

  int total = 0, bad = 0;
  int n_perr = 0, n_ferr = 0, vcyc = 0;
  int exp_perr = 0, exp_ferr = 0;
  bit m_ext = 0, m_brk = 0, exp_ovf = 0, rnd = 0;
  logic [9:0] exp_q[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: counts pulses and checks every popped entry.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (err_parity) n_perr++;
      if (err_frame) n_ferr++;
      if (code_valid) vcyc++;
      if (code_valid && code_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got %0h want none",
                   {code_ext, code_break, code_data});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({code_ext, code_break, code_data} != e) begin
            bad++;
            $display("FAIL pop_entry: got %0h want %0h",
                     {code_ext, code_break, code_data}, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (rnd) code_ready = 1'($urandom_range(0, 1));
  endtask

  // mode 1: pulse code_ready on the push cycle; mode 2: check push latency.
  task automatic bitcyc(bit d, int mode = 0);
    kdata = d;
    repeat (8) step();
    kclk = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (mode == 1 && i == FL + 2) code_ready = 1'b1;
      if (mode == 1 && i == FL + 3) code_ready = 1'b0;
      if (mode == 2 && i == FL + 2) begin #1; chk("lat_pre", code_valid, 0); end
      if (mode == 2 && i == FL + 3) begin #1; chk("lat_post", code_valid, 1); end
    end
    kclk = 1'b1;
    repeat (8) step();
  endtask

  task automatic model(logic [7:0] b, bit pflip, bit stopv, bit align);
    if (!stopv) begin
      exp_ferr++; m_ext = 0; m_brk = 0;
    end else if (pflip) begin
      exp_perr++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() < DEPTH || align) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(logic [7:0] b, bit pflip = 0, bit stopv = 1, int mode = 0);
    bit par;
    par = ~(^b) ^ pflip;
    model(b, pflip, stopv, mode == 1);
    bitcyc(1'b0);
    for (int i = 0; i < 8; i++) bitcyc(b[i]);
    bitcyc(par);
    bitcyc(stopv, mode);
    repeat (20) step();
  endtask

  task automatic chk_errs(string tag);
    chk({tag, "_perr"}, n_perr, exp_perr);
    chk({tag, "_ferr"}, n_ferr, exp_ferr);
  endtask

  task automatic drain(string tag);
    rnd = 0;
    code_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    step();
    code_ready = 1'b0;
    step();
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_lvl"}, fifo_level, 0);
  endtask

  task automatic chk_rst_outs(string tag);
    #1;
    chk({tag, "_data"}, code_data, 0);
    chk({tag, "_flags"}, {code_ext, code_break, code_valid}, 0);
    chk({tag, "_lvl"}, fifo_level, 0);
    chk({tag, "_errs"}, {err_parity, err_frame, overflow}, 0);
  endtask

  initial begin
    rst_n = 1'b0; kclk = 1'b1; kdata = 1'b1; code_ready = 1'b0;
    repeat (5) step();
    chk_rst_outs("rst");
    rst_n = 1'b1;
    repeat (10) step();

    // Single key with the consumer always ready.
    code_ready = 1'b1;
    vcyc = 0;
    send(8'h1C, 0, 1, 2);
    chk("valid_cycles", vcyc, 1);
    chk_errs("single");
    chk("single_lvl", fifo_level, 0);
    code_ready = 1'b0;

    // Prefix folding while the consumer stalls.
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("pref_lvl", fifo_level, exp_q.size());
    chk("pref_head", {code_ext, code_break, code_data}, exp_q[0]);
    send(8'h1C);
    chk("pref_lvl2", fifo_level, exp_q.size());
    drain("pref");

    // Parity error clears a pending break prefix.
    send(8'hF0);
    send(8'h1C, 1);
    chk_errs("par");
    chk("par_lvl", fifo_level, 0);
    send(8'h1C);
    drain("par");

    // Bad stop bit, then a lone clock pulse with data high (bad start).
    send(8'h55, 0, 0);
    chk_errs("stop");
    exp_ferr++; m_ext = 0; m_brk = 0;
    bitcyc(1'b1);
    repeat (20) step();
    chk_errs("start");

    // Frame abandoned after four data bits.
    exp_ferr++; m_ext = 0; m_brk = 0;
    bitcyc(1'b0);
    for (int i = 0; i < 4; i++) bitcyc(1'($urandom_range(0, 1)));
    repeat (TO + 5 + FL + 10) step();
    chk_errs("tmo");
    send(8'h1C);
    drain("tmo");

    // Random traffic with a randomly stalling consumer.
    rnd = 1;
    for (int n = 0; n < 12; n++) begin
      int pf;
      logic [7:0] b;
      pf = $urandom_range(0, 3);
      b = 8'($urandom_range(0, 8'hDF));
      if (pf == 1 || pf == 3) send(8'hE0);
      if (pf >= 2) send(8'hF0);
      send(b, ($urandom_range(0, 5) == 0));
    end
    drain("rnd");
    chk_errs("rnd");

    // Fill past capacity.
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("ovf_lvl", fifo_level, exp_q.size());
    chk("ovf_flag", overflow, exp_ovf);

    // Push lands in the same cycle as a pop while full.
    send(8'h10, 0, 1, 1);
    chk("fullpp_lvl", fifo_level, exp_q.size());
    chk("fullpp_ovf", overflow, exp_ovf);
    drain("fullpp");
    chk("ovf_sticky", overflow, 1);

    // Reset mid-frame, then a clean frame.
    bitcyc(1'b0);
    for (int i = 0; i < 3; i++) bitcyc(1'b1);
    rst_n = 1'b0;
    exp_q.delete(); m_ext = 0; m_brk = 0; exp_ovf = 0;
    repeat (3) step();
    chk_rst_outs("midrst");
    rst_n = 1'b1;
    repeat (10) step();
    send(8'h1C);
    chk("post_rst_ovf", overflow, 0);
    drain("post_rst");
    chk_errs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FILTER_LEN, default 20, is the number of consecutive stable clk cycles required before a filtered PS/2 line changes value; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 8, is the number of decoded-key entries buffered; power of two, 2..64.
REQ-003 Parameter TIMEOUT_CYC, default 100000, is the number of clk cycles without a filtered kclk falling edge after which a frame in progress is aborted; legal range 1..2^20-1.
REQ-004 clk  in  1  single system clock; all state is clocked on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 kclk  in  1  PS/2 clock pin, asynchronous to clk.
REQ-007 kdata  in  1  PS/2 data pin, asynchronous to clk.
REQ-008 code_data  out  8  scan-code byte at the FIFO head.
REQ-009 code_ext  out  1  head entry was preceded by 0xE0.
REQ-010 code_break  out  1  head entry was preceded by 0xF0 (key release).
REQ-011 code_valid  out  1  FIFO not empty.
REQ-012 code_ready  in  1  consumer accepts the head entry.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
REQ-014 err_parity  out  1  one-cycle pulse when a frame fails the odd-parity check.
REQ-015 err_frame  out  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
REQ-016 overflow  out  1  sticky flag; set when a decoded entry is dropped because the FIFO is full.

Function
REQ-017 Each pin is passed through a 2-flop synchroniser and then a filter whose output takes the new value only after the synchronised input has held it for FILTER_LEN consecutive cycles.
REQ-018 A kclk falling edge is detected as filtered kclk going 1 to 0; filtered kdata is sampled in that same cycle.
REQ-019 The frame FSM has states IDLE, DATA, PARITY and STOP.
REQ-020 In IDLE, a falling edge with kdata=0 enters DATA; with kdata=1 it pulses err_frame and stays in IDLE.
REQ-021 DATA shifts 8 bits, LSB first, then enters PARITY.
REQ-022 PARITY latches the parity bit, then enters STOP.
REQ-023 STOP always returns to IDLE.
REQ-024 At the STOP edge, checks are applied in order: stop=0 pulses err_frame; otherwise odd parity failing pulses err_parity; otherwise the byte goes to the decoder.
REQ-025 In any state other than IDLE, if TIMEOUT_CYC cycles elapse without a falling edge, the FSM returns to IDLE and pulses err_frame; the timeout counter reloads on every falling edge.
REQ-026 Decoder byte 0xE0 sets the pending-ext flag, and byte 0xF0 sets the pending-break flag; neither is pushed.
REQ-027 Decoder: any other byte pushes {ext, break, byte} to the FIFO and clears both pending flags.
REQ-028 Any err_parity or err_frame pulse clears both pending flags.
REQ-029 Latency: the push occurs on the clk edge after the STOP-edge cycle, so code_valid is high one cycle after the stop bit is detected when the FIFO was empty.
REQ-030 The FIFO is show-ahead: the head entry is driven combinationally from storage, and a pop occurs when code_valid and code_ready are both 1.
REQ-031 code_ready while empty has no effect.
REQ-032 A push while full with no pop is dropped, sets overflow, and leaves contents unchanged.
REQ-033 A push and a pop in the same cycle while full both succeed, and the level is unchanged.
REQ-034 A push and a pop in the same cycle while empty is impossible by construction, since code_valid=0.
REQ-035 Read and write pointers wrap modulo FIFO_DEPTH; fifo_level is updated the same cycle as the push or pop.

Reset
REQ-036 While rst_n=0, all outputs are 0: code_data=0x00, code_ext=0, code_break=0, code_valid=0, fifo_level=0, err_parity=0, err_frame=0, overflow=0.
REQ-037 While rst_n=0, the FSM is in IDLE, the pending flags are cleared, the filter outputs are 1 (line idle) and the FIFO pointers are 0.
REQ-038 Reset asserted mid-frame discards the partial frame; the first frame after release decodes correctly.
REQ-039 overflow clears only on reset.

Verification
REQ-040 Send frame 0x1C (parity 0) with code_ready=1 -> one entry {ext=0, break=0, 0x1C}; code_valid is high exactly one cycle; no error pulses.
REQ-041 Send 0xE0, 0xF0, 0x75 with code_ready=0 -> fifo_level=1; the head is {1, 1, 0x75}; then send 0x1C -> level=2; the second entry is {0, 0, 0x1C}.
REQ-042 Send 0x1C with the parity bit forced to 1 -> one err_parity pulse and no push; a pending 0xF0 sent before it is cleared, so a following 0x1C decodes with break=0.
REQ-043 Stop driving kclk after 4 data bits for TIMEOUT_CYC+5 cycles -> one err_frame pulse and the FSM returns to IDLE; a following 0x1C decodes correctly.
REQ-044 With FIFO_DEPTH=8 and code_ready=0, send 9 codes 0x01..0x09 -> fifo_level=8 and overflow=1; popping yields 0x01..0x08 in order and 0x09 is lost.
REQ-045 With the FIFO full, complete frame 0x10 in the same cycle as a pop -> fifo_level stays 8, overflow is unchanged and 0x10 is at the tail.
